// File: rtl/audio_iso_scheduler.sv
// audio_iso_scheduler: buffers 16-bit samples and emits one 2*SPF-byte little-endian iso packet per SOF.
// Define AUDIO_SCHED_STATS_EN to build the overflow/underflow counters and late-SOF detect.
module audio_iso_scheduler #(
   parameter int DEPTH = 64,
   parameter int SPF   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_stream_en,
   input  logic                     i_sof,
   input  logic                     i_smp_val,
   input  logic [15:0]              i_smp_data,
   output logic                     o_smp_rdy,
   input  logic                     i_tx_full,
   output logic                     o_tx_dval,
   output logic [7:0]               o_tx_data,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [7:0]               o_ovf_cnt,
   output logic [7:0]               o_udf_cnt,
   output logic                     o_late
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(SPF) + 1;

   typedef enum logic [2:0] {IDLE, ARMED, LOAD, SEND_LO, SEND_HI} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic [LW-1:0]   lvl_q, lvl_d;
   logic [15:0]     hold_q, hold_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dval_q, dval_d;
   logic [7:0]      data_q, data_d;
   logic            rdy_q, rdy_d;
   logic            pop, push, flush, wr_req;
   logic [15:0]     mem_q [DEPTH];

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      dval_d  = 1'b0;
      data_d  = data_q;
      pop     = 1'b0;
      flush   = 1'b0;
      case (state_q)
         IDLE: begin
            flush = 1'b1;
            if (i_stream_en) state_d = ARMED;
         end
         ARMED: begin
            if (!i_stream_en) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else if (i_sof) begin
               state_d = LOAD;
               cnt_d   = CW'(SPF);
            end
         end
         LOAD: begin
            // an empty FIFO pads with silence so the packet is never short
            pop     = lvl_q != '0;
            hold_d  = pop ? mem_q[rd_q] : 16'h0000;
            state_d = SEND_LO;
         end
         SEND_LO: begin
            if (!i_tx_full) begin
               dval_d  = 1'b1;
               data_d  = hold_q[7:0];
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            if (!i_tx_full) begin
               dval_d = 1'b1;
               data_d = hold_q[15:8];
               cnt_d  = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = i_stream_en ? ARMED : IDLE;
                  flush   = !i_stream_en;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      wr_req = i_smp_val && state_q != IDLE && !flush;
      push   = wr_req && (lvl_q != LW'(DEPTH) || pop);
      rd_d   = flush ? '0 : (pop ? rd_q + AW'(1) : rd_q);
      wr_d   = flush ? '0 : (push ? wr_q + AW'(1) : wr_q);
      lvl_d  = flush ? '0 : lvl_q + LW'(push) - LW'(pop);
      rdy_d  = lvl_d != LW'(DEPTH);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         rd_q    <= '0;
         wr_q    <= '0;
         lvl_q   <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         dval_q  <= 1'b0;
         data_q  <= 8'h00;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         lvl_q   <= lvl_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         dval_q  <= dval_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_q] <= i_smp_data;
   end

   assign o_smp_rdy = rdy_q;
   assign o_tx_dval = dval_q;
   assign o_tx_data = data_q;
   assign o_level   = lvl_q;

`ifdef AUDIO_SCHED_STATS_EN
   logic [7:0] ovf_q, udf_q;
   logic       late_q;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ovf_q  <= 8'h00;
         udf_q  <= 8'h00;
         late_q <= 1'b0;
      end else begin
         if (wr_req && !push && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
         if (state_q == LOAD && lvl_q == '0 && udf_q != 8'hFF) udf_q <= udf_q + 8'd1;
         late_q <= i_sof && (state_q == LOAD || state_q == SEND_LO || state_q == SEND_HI);
      end
   end
   assign o_ovf_cnt = ovf_q;
   assign o_udf_cnt = udf_q;
   assign o_late    = late_q;
`else
   assign o_ovf_cnt = 8'h00;
   assign o_udf_cnt = 8'h00;
   assign o_late    = 1'b0;
`endif
endmodule

// File: tb/tb_audio_iso_scheduler.sv
// tb_audio_iso_scheduler: directed scoreboard bench; expected bytes are queued by stimulus and
// popped by an independent negedge monitor whenever o_tx_dval is high.
module tb_audio_iso_scheduler;
   logic        clk = 1'b0;
   logic        rst, stream_en, sof, smp_val, tx_full;
   logic [15:0] smp_data;
   logic        smp_rdy, tx_dval, late;
   logic [7:0]  tx_data, ovf_cnt, udf_cnt;
   logic [6:0]  level;

   int          checks = 0;
   int          errors = 0;
   int          rx_cnt = 0;
   int          late_seen = 0;
   logic [7:0]  exp_q [$];

`ifdef AUDIO_SCHED_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   audio_iso_scheduler #(.DEPTH(64), .SPF(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_stream_en(stream_en), .i_sof(sof),
      .i_smp_val(smp_val), .i_smp_data(smp_data), .o_smp_rdy(smp_rdy),
      .i_tx_full(tx_full), .o_tx_dval(tx_dval), .o_tx_data(tx_data),
      .o_level(level), .o_ovf_cnt(ovf_cnt), .o_udf_cnt(udf_cnt), .o_late(late)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // monitor: every launched byte must match the head of the scoreboard
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (late) late_seen++;
         if (tx_dval) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got %02h with empty scoreboard (byte %0d)", tx_data, rx_cnt);
            end else begin
               e = exp_q.pop_front();
               if (tx_data !== e) begin
                  errors++;
                  $display("FAIL byte_%0d: got %02h, expected %02h", rx_cnt, tx_data, e);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_samples(input int n, input logic [15:0] base, input logic [15:0] step, input bit expect_tx);
      for (int i = 0; i < n; i++) begin
         smp_val  = 1'b1;
         smp_data = base + step * 16'(i);
         if (expect_tx && i < 16) begin
            exp_q.push_back(smp_data[7:0]);
            exp_q.push_back(smp_data[15:8]);
         end
         tick();
      end
      smp_val = 1'b0;
   endtask

   task automatic pulse_sof();
      sof = 1'b1;
      tick();
      sof = 1'b0;
   endtask

   task automatic wait_bytes(input int target);
      int n;
      n = 0;
      while (rx_cnt < target && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("wait_bytes_timeout", 32'(rx_cnt >= target), 32'd1);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
      repeat (4) tick();
   endtask

   initial begin
      int base;
      rst = 1'b1; stream_en = 1'b1; sof = 1'b0; smp_val = 1'b0; smp_data = '0; tx_full = 1'b0;
      repeat (3) tick();
      check("rst_dval", 32'(tx_dval), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_level", 32'(level), 0);
      check("rst_ovf", 32'(ovf_cnt), 0);
      check("rst_udf", 32'(udf_cnt), 0);
      check("rst_late", 32'(late), 0);
      check("rst_rdy", 32'(smp_rdy), 1);
      // first edge after reset leaves IDLE (sample discarded), second edge stores it in ARMED
      rst = 1'b0; smp_val = 1'b1; smp_data = 16'h1234;
      tick();
      check("idle_discard_level", 32'(level), 0);
      tick();
      smp_val = 1'b0;
      check("armed_after_1cyc_level", 32'(level), 1);
      stream_en = 1'b0;
      tick();
      tick();
      check("disable_flush_level", 32'(level), 0);
      stream_en = 1'b1;
      tick();

      // full packet
      push_samples(16, 16'h0100, 16'h0001, 1'b1);
      check("full_level_pre", 32'(level), 16);
      pulse_sof();
      check("lat_k", 32'(tx_dval), 0);
      tick();
      check("lat_k1", 32'(tx_dval), 0);
      tick();
      check("lat_k2_first_dval", 32'(tx_dval), 1);
      drain("full_drain");
      check("full_level_post", 32'(level), 0);
      check("full_udf", 32'(udf_cnt), 0);

      // underflow: 10 real samples then 6 zero samples
      push_samples(10, 16'hA550, 16'h0101, 1'b1);
      for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
      pulse_sof();
      drain("udf_drain");
      check("udf_cnt", 32'(udf_cnt), 32'(6 * STATS));
      check("udf_level", 32'(level), 0);

      // backpressure after byte 7
      push_samples(16, 16'hC040, 16'h0101, 1'b1);
      base = rx_cnt;
      pulse_sof();
      wait_bytes(base + 7);
      tx_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_no_dval", 32'(tx_dval), 0);
      end
      tx_full = 1'b0;
      drain("bp_drain");
      check("bp_count", 32'(rx_cnt - base), 32);

      // late SOF at byte 10, then disable mid-packet
      push_samples(16, 16'h8000, 16'h0203, 1'b1);
      base = rx_cnt;
      pulse_sof();
      wait_bytes(base + 10);
      pulse_sof();
      stream_en = 1'b0;
      push_samples(3, 16'h7777, 16'h0001, 1'b0);
      drain("late_drain");
      check("late_len", 32'(rx_cnt - base), 32);
      check("late_pulses", 32'(late_seen), 32'(STATS));
      check("disable_level", 32'(level), 0);
      push_samples(1, 16'h4444, 16'h0000, 1'b0);
      pulse_sof();
      repeat (4) tick();
      check("idle_level", 32'(level), 0);

      // overflow, then reset mid-packet
      stream_en = 1'b1;
      tick();
      push_samples(67, 16'h0000, 16'h0001, 1'b1);
      check("ovf_level", 32'(level), 64);
      check("ovf_rdy", 32'(smp_rdy), 0);
      check("ovf_cnt", 32'(ovf_cnt), 32'(3 * STATS));
      base = rx_cnt;
      pulse_sof();
      wait_bytes(base + 4);
      rst = 1'b1;
      exp_q.delete();
      tick();
      tick();
      check("rstmid_dval", 32'(tx_dval), 0);
      check("rstmid_level", 32'(level), 0);
      check("rstmid_rdy", 32'(smp_rdy), 1);
      check("rstmid_ovf", 32'(ovf_cnt), 0);
      rst = 1'b0;
      repeat (4) tick();
      check("rstmid_no_bytes", 32'(rx_cnt - base), 4);
      check("final_sb_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/audio_iso_scheduler.md
# audio_iso_scheduler

Schedules the processed microphone stream into USB isochronous packets. It buffers 16-bit samples from the FIR output in an internal sample FIFO. On each USB SOF, while the streaming alternate setting is active, it emits exactly one fixed-length packet of little-endian bytes into the endpoint-2 TX path of `usb_fifo`. It sits between `Advanced_FIR_Filter_Top` and `usb_fifo` in the `PHY_CLKOUT` domain.

## Interface
Parameters:
- `DEPTH`, 64 — sample FIFO depth in 16-bit words; must be a power of two, ≥ 2·`SPF`.
- `SPF`, 16 — samples per packet; packet length is 2·`SPF` bytes.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1 — `PHY_CLKOUT`.
- `i_reset` in 1 — synchronous, active-high.
- `i_stream_en` in 1 — 1 when the streaming interface alternate setting is nonzero.
- `i_sof` in 1 — one-cycle SOF pulse from the device controller.
- `i_smp_val` in 1 — sample strobe.
- `i_smp_data` in 16 — signed sample.
- `o_smp_rdy` out 1 — FIFO not full (informational; the upstream does not stall).
- `i_tx_full` in 1 — EP2 TX FIFO cannot take a byte this cycle.
- `o_tx_dval` out 1 — byte strobe to `i_ep2_tx_dval`.
- `o_tx_data` out 8 — byte to `i_ep2_tx_data`.
- `o_level` out log2(`DEPTH`)+1 — FIFO occupancy.
- `o_ovf_cnt` out 8 — dropped-sample count, saturating.
- `o_udf_cnt` out 8 — zero-padded-sample count, saturating.
- `o_late` out 1 — one-cycle pulse when an SOF arrives while a packet is in progress.

## Operation
- States: IDLE, ARMED, LOAD, SEND_LO, SEND_HI.
- IDLE: FIFO held empty. Incoming samples are discarded without counting; `o_smp_rdy`=1. If `i_stream_en`=1, go to ARMED.
- ARMED: samples are written into the FIFO.
  - `i_stream_en`=0: go to IDLE and flush the FIFO.
  - `i_sof`=1: go to LOAD with remaining count = `SPF`.
- LOAD:
  - FIFO nonempty: pop the head sample into the holding register.
  - FIFO empty: load 0x0000 and increment `o_udf_cnt`.
  - Then go to SEND_LO.
- SEND_LO: if `i_tx_full`=0, drive the holding register's low byte with `o_tx_dval`=1 on the next cycle and go to SEND_HI. Otherwise `o_tx_dval`=0 and stay.
- SEND_HI: if `i_tx_full`=0, drive the high byte and decrement the count.
  - Count reaches 0: go to ARMED if `i_stream_en`, else go to IDLE and flush.
  - Count nonzero: go to LOAD.
  - `i_tx_full`=1: stay.
- Every packet carries exactly 2·`SPF` bytes. Shortfall is padded with zero samples; packets are never truncated.
- Write while full: the sample is dropped and `o_ovf_cnt` increments (saturates at 255).
- A push and a pop in the same cycle are both performed; `o_level` is unchanged.
- `i_sof` in LOAD, SEND_LO or SEND_HI: ignored. `o_late` pulses on the next cycle and the current packet continues.
- `i_stream_en` falling mid-packet: the packet completes, then the block goes to IDLE and flushes.
- Read and write pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`. The level is tracked separately.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - `o_tx_dval`=0, `o_tx_data`=0x00.
  - `o_level`=0, `o_ovf_cnt`=0, `o_udf_cnt`=0, `o_late`=0.
  - `o_smp_rdy`=1.
- Reset mid-packet aborts the packet immediately; no further bytes are emitted.
- `i_sof` sampled at edge k, with `i_tx_full` low: pop at edge k+1, first `o_tx_dval` high during cycle k+2.
- Unstalled throughput: one sample per 3 cycles. Packet duration is 3·`SPF` cycles minimum.
- `o_tx_dval`/`o_tx_data` are registered. `i_tx_full` is sampled on the edge that would launch a byte, so the downstream FIFO needs one entry of slack.
- `o_smp_rdy` and `o_level` are registered and reflect state after the previous edge.

## Configuration
- `AUDIO_SCHED_STATS_EN` defined: `o_ovf_cnt`, `o_udf_cnt` and `o_late` operate as specified.
- Undefined: counters and the late-detect logic are not built; `o_ovf_cnt`=0, `o_udf_cnt`=0 and `o_late`=0 constantly. Dataflow is identical.

## Test plan
- Reset, with `i_stream_en`=1 held during reset:
  - All outputs take their reset values.
  - The state reaches ARMED one cycle after `i_reset` falls.
- Full packet:
  - Stimulus: push 16 samples 0x0100–0x010F, then SOF.
  - Expect 32 bytes 00,01,01,01,…,0F,01, with the first `o_tx_dval` 2 cycles after SOF.
  - Expect `o_level`=0 and `o_udf_cnt`=0 afterwards.
- Underflow: push 10 samples, then SOF. Expect 10 data samples followed by 12 zero bytes, and `o_udf_cnt`=6.
- Overflow: with `DEPTH`=64, push 67 samples and no SOF. Expect `o_ovf_cnt`=3, `o_smp_rdy`=0 and `o_level`=64.
- Backpressure: hold `i_tx_full`=1 for 5 cycles after byte 7. Expect no `o_tx_dval` during the stall and the byte sequence intact with no loss or duplication.
- Late SOF and disable:
  - SOF at byte 10 of a packet: expect an `o_late` pulse and an unchanged packet length.
  - Drop `i_stream_en` mid-packet: expect the packet to complete, then IDLE with `o_level`=0.
